spi_xfer_sequencer: RTL
=======================

Name: spi_xfer_sequencer

Overview:
Master-mode SPI transfer controller that drives the 8-bit SPI shift register.
- Generates SCLK from PCLK using the SPPR/SPR baud divisor.
- Drives slave select.
- Issues the load pulse (send_data) and capture pulse (receive_data) to the shift register.
- Issues the per-edge launch/sample strobes for all four CPOL/CPHA modes.
- Sits between the APB slave register file and the shift register.

Parameters:
- DIV_W, 12, width of the baud half-period counter. Must hold (7+1)*2^8 = 2048.

Ports:
- PCLK  in  1  system clock.
- PRESET_n  in  1  reset: asynchronous, active-low.
- mstr_i  in  1  master mode enable (CR1.MSTR).
- spe_i  in  1  SPI system enable (CR1.SPE).
- start_i  in  1  one-cycle pulse on APB write of the data register.
- cpol_i  in  1  clock polarity.
- cphase_i  in  1  clock phase.
- sppr_i  in  3  baud pre-selection.
- spr_i  in  3  baud selection.
- send_data_o  out  1  one-cycle load strobe to the shift register.
- receive_data_o  out  1  one-cycle capture strobe to the shift register.
- ss_o  out  1  slave select, active-low.
- sclk_o  out  1  SPI clock.
- mosi_send_sclk_o  out  1  launch strobe preceding an SCLK falling edge.
- mosi_send_sclk0_o  out  1  launch strobe preceding an SCLK rising edge.
- miso_receive_sclk_o  out  1  sample strobe preceding an SCLK rising edge.
- miso_receive_sclk0_o  out  1  sample strobe preceding an SCLK falling edge.
- busy_o  out  1  high from LOAD through DONE.
- spif_o  out  1  one-cycle transfer-complete pulse.

Behaviour:
- Reset values: ss_o=1, sclk_o=0, all other outputs 0, state=IDLE, counters=0.
- Baud:
  - divisor = (sppr+1) * 2^(spr+1).
  - half = divisor/2, range 1..1024.
  - Computed at DIV_W bits with zero-extension; no overflow is possible.
- Baud tick:
  - The half counter runs 0..half-1 in SETUP, XFER and HOLD.
  - tick = (cnt == half-1). The counter wraps to 0 on tick.
- Config latching: cpol, cpha and half are latched in LOAD. Changes during a transfer are ignored until the next transfer.
- Strobes:
  - All strobes are asserted during the PCLK cycle in which tick=1.
  - At the closing PCLK edge of that cycle, sclk_o toggles and the shift register acts.
  - Strobe type follows the direction of the upcoming SCLK edge, as defined in Ports.
- State machine:
  - IDLE:
    - sclk_o = cpol_i (registered), ss_o = 1.
    - start_i && spe_i && mstr_i -> LOAD.
  - LOAD (1 cycle): send_data_o = 1, latch config. -> SETUP.
  - SETUP (half cycles):
    - ss_o = 0, sclk_o = latched cpol.
    - On tick -> XFER. If cpha = 0, also assert the first launch strobe on that tick; sclk does not toggle.
  - XFER (16 ticks):
    - Each tick toggles sclk_o and increments edge_cnt (1..16).
    - cpha = 1: launch on edges 1,3,...,15; sample on edges 2,4,...,16.
    - cpha = 0: launch on edges 2,4,...,14, with no launch on edge 16; sample on edges 1,3,...,15.
    - Exactly 8 launches and 8 samples occur per transfer.
    - After tick 16 -> HOLD. sclk_o equals cpol at this point.
  - HOLD (half cycles): ss_o = 0. On tick -> DONE.
  - DONE (1 cycle): receive_data_o = 1, spif_o = 1, ss_o = 1. -> IDLE.
- Latency: start_i to spif_o high = 2 + 18*half cycles.
- Boundary conditions:
  - start_i while busy_o: ignored, no queueing.
  - start_i coincident with DONE: ignored.
  - spe_i or mstr_i falls mid-transfer:
    - Next cycle: IDLE, ss_o = 1, sclk_o = cpol_i.
    - No spif_o, no receive_data_o; counters cleared.
  - PRESET_n mid-transfer: immediate return to the reset values.
  - half = 1: a tick occurs every cycle, and strobes on consecutive cycles are legal.
  - In any one cycle, at most one launch strobe and one sample strobe are high.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE, LOAD, SETUP, XFER, HOLD, DONE);
  - DIV_W;
  - EDGES_PER_XFER = 16;
  - a function computing half from sppr/spr.
- One sub-module, spi_baud_gen: the half counter plus tick output, with inputs for enable, clear and the latched half value.

Test Plan:
- Mode 0, sppr=0, spr=0 (half = 1), start pulse:
  - send_data at cycle 1, ss_o low cycles 2-19.
  - Exactly 16 sclk toggles and 8 mosi_send_sclk_o / 8 miso_receive_sclk_o pulses; no "0"-variant strobes.
  - spif_o and receive_data_o at cycle 20.
- Mode 3, sppr=1, spr=1 (half = 4):
  - sclk idles at 1.
  - Launches on falling edges via mosi_send_sclk_o and samples on rising edges via miso_receive_sclk_o.
  - spif_o at cycle 74.
- Modes 1 and 2:
  - Only the "0"-variant strobes pulse, 8 each.
  - Mode 1: first launch precedes a rising edge.
  - Mode 2: first sample precedes a falling edge.
- Change cpol and spr mid-transfer, then issue a second start while busy:
  - Current transfer timing is unchanged; the second start is ignored.
  - The next transfer uses the new config.
- Drop spe_i at edge 7:
  - Next cycle ss_o = 1 and sclk_o = cpol.
  - No spif_o; busy_o = 0.
  - A new start succeeds normally.
- Assert PRESET_n low mid-XFER: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer sequencer.
//   - state_e        : sequencer states
//   - DIV_W          : width of the baud half-period counter
//   - HALF_W         : width needed for a half period of 1..1024
//   - EDGES_PER_XFER : SCLK edges in one 8-bit transfer
//   - calc_half()    : half period in PCLK cycles from SPPR/SPR
package spi_pkg;

    localparam int DIV_W          = 12;
    localparam int HALF_W         = 11;
    localparam int EDGES_PER_XFER = 16;
    localparam int EDGE_W         = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        XFER  = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_e;

    // divisor = (sppr+1) * 2^(spr+1), so half = (sppr+1) << spr (1..1024)
    function automatic logic [HALF_W-1:0] calc_half(input logic [2:0] sppr,
                                                    input logic [2:0] spr);
        logic [HALF_W-1:0] base;
        base = {{(HALF_W-3){1'b0}}, sppr} + HALF_W'(1);
        return base << spr;
    endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Baud half-period counter for the SPI sequencer.
// Counts 0..half_i-1 while enabled and flags the last count as a tick.
// Ports:
//   PCLK, PRESET_n : clock, asynchronous active-low reset
//   en_i           : count enable (hold when low)
//   clr_i          : synchronous clear, overrides enable
//   half_i         : half period in PCLK cycles (>= 1)
//   tick_o         : high in the cycle where the count equals half_i-1
module spi_baud_gen #(
    parameter int DIV_W = 12
) (
    input  logic             PCLK,
    input  logic             PRESET_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] half_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == (half_i - DIV_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Master-mode SPI transfer sequencer. Generates SCLK from PCLK, drives slave
// select, and strobes the 8-bit shift register (load, capture, per-edge
// launch/sample) for all four CPOL/CPHA modes.
// Ports:
//   PCLK, PRESET_n        : clock, asynchronous active-low reset
//   mstr_i, spe_i         : master enable, system enable (both needed to run)
//   start_i               : one-cycle pulse requesting a transfer
//   cpol_i, cphase_i      : clock polarity / phase
//   sppr_i, spr_i         : baud pre-selection / selection
//   send_data_o           : load strobe (LOAD)
//   receive_data_o        : capture strobe (DONE)
//   ss_o                  : slave select, active-low
//   sclk_o                : SPI clock
//   mosi_send_sclk_o      : launch strobe before an SCLK falling edge
//   mosi_send_sclk0_o     : launch strobe before an SCLK rising edge
//   miso_receive_sclk_o   : sample strobe before an SCLK rising edge
//   miso_receive_sclk0_o  : sample strobe before an SCLK falling edge
//   busy_o                : transfer in progress (LOAD..DONE)
//   spif_o                : transfer-complete pulse
//
// state | meaning
// IDLE  | waiting for start, SCLK follows cpol_i, SS high
// LOAD  | load strobe, latch cpol/cpha/half
// SETUP | SS low for one half period before the first edge
// XFER  | 16 SCLK edges, one per tick
// HOLD  | SS held low one half period after the last edge
// DONE  | capture strobe + completion pulse, SS high
module spi_xfer_sequencer #(
    parameter int DIV_W = 12
) (
    input  logic       PCLK,
    input  logic       PRESET_n,
    input  logic       mstr_i,
    input  logic       spe_i,
    input  logic       start_i,
    input  logic       cpol_i,
    input  logic       cphase_i,
    input  logic [2:0] sppr_i,
    input  logic [2:0] spr_i,
    output logic       send_data_o,
    output logic       receive_data_o,
    output logic       ss_o,
    output logic       sclk_o,
    output logic       mosi_send_sclk_o,
    output logic       mosi_send_sclk0_o,
    output logic       miso_receive_sclk_o,
    output logic       miso_receive_sclk0_o,
    output logic       busy_o,
    output logic       spif_o
);

    import spi_pkg::*;

    state_e             state_q, state_d;
    logic               sclk_q, sclk_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic [DIV_W-1:0]   half_q, half_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;

    logic               tick;
    logic               counting;
    logic               abort;
    logic               launch;
    logic               sample;
    logic               launch_falling;
    logic [EDGE_W-1:0]  edge_nxt;
    logic               send_data;
    logic               done_pulse;

    assign counting = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
    assign abort    = (state_q != IDLE) && !(spe_i && mstr_i);
    assign edge_nxt = edge_q + EDGE_W'(1);

    spi_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .en_i     (counting),
        .clr_i    (!counting || abort),
        .half_i   (half_q),
        .tick_o   (tick)
    );

    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        half_d     = half_q;
        edge_d     = edge_q;
        launch     = 1'b0;
        sample     = 1'b0;
        send_data  = 1'b0;
        done_pulse = 1'b0;

        if (abort) begin
            state_d = IDLE;
            sclk_d  = cpol_i;
            edge_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sclk_d = cpol_i;
                    edge_d = '0;
                    if (start_i && spe_i && mstr_i) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    send_data = 1'b1;
                    cpol_d    = cpol_i;
                    cpha_d    = cphase_i;
                    half_d    = DIV_W'(calc_half(sppr_i, spr_i));
                    sclk_d    = cpol_i;
                    state_d   = SETUP;
                end
                SETUP: begin
                    sclk_d = cpol_q;
                    if (tick) begin
                        state_d = XFER;
                        launch  = !cpha_q;
                    end
                end
                XFER: begin
                    if (tick) begin
                        sclk_d = !sclk_q;
                        edge_d = edge_nxt;
                        if (cpha_q) begin
                            launch = edge_nxt[0];
                            sample = !edge_nxt[0];
                        end else begin
                            launch = !edge_nxt[0] && (edge_nxt != EDGE_W'(EDGES_PER_XFER));
                            sample = edge_nxt[0];
                        end
                        if (edge_q == EDGE_W'(EDGES_PER_XFER - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    edge_d = '0;
                    if (tick) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done_pulse = 1'b1;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The cpha=0 pre-launch in SETUP has no SCLK edge of its own; it is
    // classed as if SCLK had just arrived at cpol, so it uses the same strobe
    // variant as every other launch of that mode.
    assign launch_falling = (state_q == SETUP) ? !cpol_q : sclk_q;

    assign mosi_send_sclk_o     = launch && launch_falling;
    assign mosi_send_sclk0_o    = launch && !launch_falling;
    assign miso_receive_sclk_o  = sample && !sclk_q;
    assign miso_receive_sclk0_o = sample && sclk_q;
    assign send_data_o          = send_data;
    assign receive_data_o       = done_pulse;
    assign spif_o               = done_pulse;
    assign ss_o                 = !counting;
    assign sclk_o               = sclk_q;
    assign busy_o               = (state_q != IDLE);

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            half_q  <= '0;
            edge_q  <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            half_q  <= half_d;
            edge_q  <= edge_d;
        end
    end

endmodule
